// File: rtl/acdc_host_pkg.sv
// acdc_host_pkg: shared state encoding and default geometry for the acdc_host harness
package acdc_host_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_e;
  localparam logic [7:0]  RES_BASE_DEF = 8'h00;
  localparam logic [7:0]  RES_LEN_DEF  = 8'd4;
  localparam logic [15:0] TIMEOUT_DEF  = 16'hFFFF;
endpackage

// File: rtl/acdc_host_if.sv
// acdc_host_if: control, preload, CPU, data-memory and result-stream signals of acdc_host
interface acdc_host_if;
  logic        go;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        dut_start;
  logic        dut_halt;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [15:0] cycle_count;
  modport master (
    input  go, ld_valid, ld_addr, ld_data, ld_last, dut_halt, mem_rd_data, res_ready,
    output busy, done, timeout, ld_ready, dut_start, mem_wr_en, mem_addr, mem_wr_data,
           res_valid, res_data, cycle_count
  );
  modport slave (
    output go, ld_valid, ld_addr, ld_data, ld_last, dut_halt, mem_rd_data, res_ready,
    input  busy, done, timeout, ld_ready, dut_start, mem_wr_en, mem_addr, mem_wr_data,
           res_valid, res_data, cycle_count
  );
endinterface

// File: rtl/acdc_host_watchdog.sv
// acdc_host_watchdog: saturating RUN-cycle counter; expire only built with ACDC_HOST_WATCHDOG_EN
module acdc_host_watchdog
  import acdc_host_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count,
  output logic        expire
);
  logic [15:0] count_q, count_d;
  always_comb begin
    count_d = clr ? 16'd0 : (en && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  end
  always_ff @(posedge CLK) begin
    count_q <= !reset_n ? 16'd0 : count_d;
  end
  assign count = count_q;
`ifdef ACDC_HOST_WATCHDOG_EN
  // judged on the post-increment value so the Nth RUN cycle is the one that expires
  assign expire = en && count_d >= TIMEOUT;
`else
  assign expire = 1'b0;
`endif
endmodule

// File: rtl/acdc_host.sv
// acdc_host: preload memory, run the CPU until halt, drain results; watchdog abort with ACDC_HOST_WATCHDOG_EN
module acdc_host
  import acdc_host_pkg::*;
#(
  parameter logic [7:0]  RES_BASE = RES_BASE_DEF,
  parameter logic [7:0]  RES_LEN  = RES_LEN_DEF,
  parameter logic [15:0] TIMEOUT  = TIMEOUT_DEF
) (
  input logic         CLK,
  input logic         reset_n,
  acdc_host_if.master h
);
  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        timeout_q, timeout_d;
  logic [15:0] count;
  logic        expire;
  logic        wd_clr;
  logic        wd_en;
  logic        halt_ok;
  assign wd_clr  = state_q == S_IDLE && h.go;
  assign wd_en   = state_q == S_RUN;
  // count is still zero only in the first RUN cycle, while the PC leaves init
  assign halt_ok = h.dut_halt && count != 16'd0;
  acdc_host_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .count   (count),
    .expire  (expire)
  );
  always_comb begin
    h.busy        = state_q != S_IDLE;
    h.done        = state_q == S_DONE;
    h.timeout     = timeout_q;
    h.dut_start   = state_q == S_IDLE || state_q == S_LOAD || state_q == S_ABORT;
    h.ld_ready    = state_q == S_LOAD;
    h.mem_wr_en   = state_q == S_LOAD && h.ld_valid;
    h.mem_addr    = state_q == S_LOAD ? h.ld_addr : state_q == S_DRAIN ? RES_BASE + idx_q : 8'd0;
    h.mem_wr_data = h.mem_wr_en ? h.ld_data : 8'd0;
    h.res_valid   = state_q == S_DRAIN;
    h.res_data    = state_q == S_DRAIN ? h.mem_rd_data : 8'd0;
    h.cycle_count = count;
  end
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (h.go) begin
        state_d   = S_LOAD;
        timeout_d = 1'b0;
      end
      S_LOAD: if (h.ld_valid && h.ld_last) state_d = S_RUN;
      S_RUN: if (halt_ok) begin
        state_d = RES_LEN == 8'd0 ? S_DONE : S_DRAIN;
        idx_d   = 8'd0;
      end else if (expire) begin
        state_d   = S_ABORT;
        timeout_d = 1'b1;
      end
      S_DRAIN: if (h.res_ready) begin
        state_d = idx_q == RES_LEN - 8'd1 ? S_DONE : S_DRAIN;
        idx_d   = idx_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: doc/acdc_host.md
ACDC_HOST -- requirements
Module: acdc_host

Interface
REQ-001 SHALL have parameter RES_BASE, default 8'h00, first data-memory address drained after halt.
REQ-002 SHALL have parameter RES_LEN, default 8'd4, number of result bytes drained (0 = none).
REQ-003 SHALL have parameter TIMEOUT, default 16'hFFFF, maximum RUN cycles before abort.
REQ-004 SHALL have ports: CLK  in  1  clock, posedge only; reset_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: go  in  1  run request; busy  out  1  not IDLE; done  out  1  one-cycle completion pulse; timeout  out  1  sticky abort flag.
REQ-006 SHALL have ports: ld_valid  in  1; ld_ready  out  1; ld_addr  in  8; ld_data  in  8; ld_last  in  1  final preload beat.
REQ-007 SHALL have ports: dut_start  out  1  to CPU start (active-high init); dut_halt  in  1  CPU halt flag.
REQ-008 SHALL have ports: mem_wr_en  out  1; mem_addr  out  8; mem_wr_data  out  8; mem_rd_data  in  8  combinational read data.
REQ-009 SHALL have ports: res_valid  out  1; res_ready  in  1; res_data  out  8; cycle_count  out  16  RUN cycles of last run.

Function
REQ-010 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE, ABORT.
REQ-011 IDLE: dut_start=1; go=1 -> LOAD, clear timeout and cycle_count; go ignored in any other state.
REQ-012 LOAD: dut_start=1, ld_ready=1; on ld_valid&&ld_ready drive mem_wr_en=1, mem_addr=ld_addr, mem_wr_data=ld_data same cycle (combinational pass-through).
REQ-013 LOAD: accepted beat with ld_last=1 -> RUN next cycle; ld_last on first beat is legal (single-byte preload).
REQ-014 RUN: dut_start=0, mem_wr_en=0; cycle_count increments every RUN cycle, saturating at 16'hFFFF.
REQ-015 RUN: dut_halt ignored in first RUN cycle (PC leaving init); afterwards dut_halt=1 -> DRAIN, or DONE if RES_LEN=0.
REQ-016 DRAIN: mem_addr=RES_BASE+idx (8-bit wrap at 255->0), idx 0..RES_LEN-1; res_data=mem_rd_data, res_valid=1.
REQ-017 DRAIN: idx advances only on res_valid&&res_ready; res_data stable while res_valid&&!res_ready; last transfer -> DONE.
REQ-018 DONE: done=1 for exactly one cycle, dut_start=0; -> IDLE.
REQ-019 ABORT: timeout=1 (held until next accepted go), no drain, done not asserted; -> IDLE next cycle.
REQ-020 busy=1 in every state except IDLE; ld_ready and res_valid 0 outside LOAD and DRAIN respectively.
REQ-021 Simultaneous dut_halt and timeout expiry in the same RUN cycle: halt wins.

Reset
REQ-022 reset_n=0 at posedge SHALL force IDLE from any state, including mid-LOAD and mid-DRAIN.
REQ-023 Reset values: dut_start=1, busy=0, done=0, timeout=0, ld_ready=0, res_valid=0, mem_wr_en=0, mem_addr=0, cycle_count=0.

Configuration
REQ-024 Macro ACDC_HOST_WATCHDOG_EN defined: RUN cycle_count reaching TIMEOUT without halt -> ABORT.
REQ-025 Macro undefined: RUN waits indefinitely for dut_halt, ABORT unreachable, timeout tied 0.

Structure
REQ-026 Package acdc_host_pkg SHALL hold the state enum and default RES_BASE/RES_LEN/TIMEOUT constants.
REQ-027 Cycle counter plus timeout compare SHALL be sub-module acdc_host_watchdog (clear, enable, saturate, expire outputs).

Verification
REQ-028 Preload 3 beats (addr 0x10/0x11/0x12, data A5/5A/FF, last on third) -> three mem_wr_en pulses, dut_start falls on cycle after third beat.
REQ-029 DUT model raises halt after 20 RUN cycles, RES_BASE=0x10, RES_LEN=3 -> res_data A5,5A,FF then done pulse, cycle_count=20.
REQ-030 res_ready held low 5 cycles during second drain byte -> res_data holds 5A, mem_addr holds 0x11, no byte lost.
REQ-031 With ACDC_HOST_WATCHDOG_EN, TIMEOUT=8, halt never rises -> ABORT after 8 RUN cycles, timeout=1, no done; next go clears timeout.
REQ-032 RES_BASE=0xFE, RES_LEN=4 -> drain addresses FE,FF,00,01.
REQ-033 reset_n low mid-DRAIN -> next cycle IDLE, dut_start=1, res_valid=0, busy=0.
